// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit types: sequencer state codes,
// immediate-ALU opcode constants and class decode.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_FAULT = 4'd7
  } state_t;

  localparam logic [4:0] OPC_ADDI = 5'b01100;
  localparam logic [4:0] OPC_ANDI = 5'b01101;
  localparam logic [4:0] OPC_ORI  = 5'b01110;

  function automatic logic is_imm_alu(
    input logic [4:0] opc
  );
    return (opc == OPC_ADDI) ||
           (opc == OPC_ANDI) ||
           (opc == OPC_ORI);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-ready wait counter shared by the fetch/load/store
// sequencers; expire flags the step that reaches the limit.
module mem_wait_timer #(
  parameter int WAIT_W = 4
) (
  input  logic Clock,
  input  logic clr,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [WAIT_W-1:0] PRE_LIMIT =
    {{(WAIT_W-1){1'b1}}, 1'b0};

  logic [WAIT_W-1:0] count;

  // expire fires when this enabled step lands on all-ones
  assign expire = enable && (count == PRE_LIMIT);

  // count wait cycles; clear restarts from zero
  always_ff @(posedge Clock) begin
    if (clr || clear)
      count <= '0;
    else if (enable)
      count <= count + WAIT_W'(1);
  end

endmodule

// File: rtl/imm_alu_sequencer.sv
// Fetch/execute control-step generator for ADDI/ANDI/ORI,
// with memory wait timeout, illegal trap and run mode.
import cpu_ctrl_pkg::*;

module imm_alu_sequencer #(
  parameter int IR_W    = 32,
  parameter int OPC_LSB = 27,
  parameter int OPC_W   = 5,
  parameter int WAIT_W  = 4
) (
  input  logic            Clock,
  input  logic            clr,
  input  logic            start,
  input  logic            run_mode,
  input  logic            stop,
  input  logic            mem_ready,
  input  logic [IR_W-1:0] IR_in,
  output logic            PC_out,
  output logic            MAR_enable,
  output logic            IncPC,
  output logic            PC_enable,
  output logic            Read,
  output logic            MDR_enable,
  output logic            MDR_out,
  output logic            IR_enable,
  output logic            Grb,
  output logic            BA_out,
  output logic            Y_enable,
  output logic            C_out,
  output logic            Z_enable,
  output logic            ZLow_out,
  output logic            Gra,
  output logic            R_in,
  output logic [OPC_W-1:0] alu_op,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic            timeout,
  output logic [3:0]      state_dbg
);

  state_t           state;
  logic [OPC_W-1:0] opc;
  logic             legal;
  logic             wait_en;
  logic             wait_clr;
  logic             wait_exp;
  logic             timeout_q;

  assign opc   = IR_in[OPC_LSB +: OPC_W];
  assign legal = is_imm_alu(5'(opc));

  assign wait_en  = (state == S_T1) && !mem_ready;
  assign wait_clr = (state != S_T1) || mem_ready;

  mem_wait_timer #(
    .WAIT_W (WAIT_W)
  ) u_wait (
    .Clock  (Clock),
    .clr    (clr),
    .clear  (wait_clr),
    .enable (wait_en),
    .expire (wait_exp)
  );

  // control-step state machine and sticky timeout flag
  always_ff @(posedge Clock) begin
    if (clr) begin
      state     <= S_IDLE;
      timeout_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE:
          if (start) state <= S_T0;
        S_T0:
          state <= S_T1;
        S_T1:
          if (mem_ready) begin
            state <= S_T2;
          end else if (wait_exp) begin
            state     <= S_FAULT;
            timeout_q <= 1'b1;
          end
        S_T2:
          state <= S_T3;
        S_T3:
          state <= legal ? S_T4 : S_IDLE;
        S_T4:
          state <= S_T5;
        S_T5:
          state <= (run_mode && !stop) ? S_T0 : S_IDLE;
        S_FAULT:
          state <= S_FAULT;
        default:
          state <= S_IDLE;
      endcase
    end
  end

  // Moore strobe decode; T3 and T4 also look at the loaded IR
  always_comb begin
    PC_out     = 1'b0;
    MAR_enable = 1'b0;
    IncPC      = 1'b0;
    PC_enable  = 1'b0;
    Read       = 1'b0;
    MDR_enable = 1'b0;
    MDR_out    = 1'b0;
    IR_enable  = 1'b0;
    Grb        = 1'b0;
    BA_out     = 1'b0;
    Y_enable   = 1'b0;
    C_out      = 1'b0;
    Z_enable   = 1'b0;
    ZLow_out   = 1'b0;
    Gra        = 1'b0;
    R_in       = 1'b0;
    alu_op     = '0;
    done       = 1'b0;
    illegal    = 1'b0;
    unique case (state)
      S_T0: begin
        PC_out     = 1'b1;
        MAR_enable = 1'b1;
        IncPC      = 1'b1;
        PC_enable  = 1'b1;
      end
      S_T1: begin
        Read       = 1'b1;
        MDR_enable = 1'b1;
      end
      S_T2: begin
        MDR_out    = 1'b1;
        IR_enable  = 1'b1;
      end
      S_T3: begin
        Grb      = legal;
        BA_out   = legal;
        Y_enable = legal;
        illegal  = !legal;
      end
      S_T4: begin
        C_out    = 1'b1;
        Z_enable = 1'b1;
        alu_op   = opc;
      end
      S_T5: begin
        ZLow_out = 1'b1;
        Gra      = 1'b1;
        R_in     = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = (state != S_IDLE) && (state != S_FAULT);
  assign timeout   = timeout_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_imm_alu_sequencer.sv
// Self-checking bench for imm_alu_sequencer: vector table
// with scoreboard plus timeout, run-mode and clr sequences.
import cpu_ctrl_pkg::*;

module tb_imm_alu_sequencer;

  logic        Clock;
  logic        clr;
  logic        start;
  logic        run_mode;
  logic        stop;
  logic        mem_ready;
  logic [31:0] IR_in;
  logic PC_out, MAR_enable, IncPC, PC_enable;
  logic Read, MDR_enable, MDR_out, IR_enable;
  logic Grb, BA_out, Y_enable, C_out;
  logic Z_enable, ZLow_out, Gra, R_in;
  logic [4:0] alu_op;
  logic busy, done, illegal, timeout;
  logic [3:0] state_dbg;
  logic [28:0] outs_all;

  int n_pass;
  int n_total;
  bit mon_en;

  typedef struct {
    logic [4:0] opc;
    int         w;
    bit         legal;
    int         lat;
  } vec_t;

  typedef struct {
    bit legal;
    int lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];

  imm_alu_sequencer dut (
    .Clock      (Clock),
    .clr        (clr),
    .start      (start),
    .run_mode   (run_mode),
    .stop       (stop),
    .mem_ready  (mem_ready),
    .IR_in      (IR_in),
    .PC_out     (PC_out),
    .MAR_enable (MAR_enable),
    .IncPC      (IncPC),
    .PC_enable  (PC_enable),
    .Read       (Read),
    .MDR_enable (MDR_enable),
    .MDR_out    (MDR_out),
    .IR_enable  (IR_enable),
    .Grb        (Grb),
    .BA_out     (BA_out),
    .Y_enable   (Y_enable),
    .C_out      (C_out),
    .Z_enable   (Z_enable),
    .ZLow_out   (ZLow_out),
    .Gra        (Gra),
    .R_in       (R_in),
    .alu_op     (alu_op),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal),
    .timeout    (timeout),
    .state_dbg  (state_dbg)
  );

  assign outs_all = {
    PC_out, MAR_enable, IncPC, PC_enable,
    Read, MDR_enable, MDR_out, IR_enable,
    Grb, BA_out, Y_enable, C_out,
    Z_enable, ZLow_out, Gra, R_in,
    alu_op, busy, done, illegal, timeout,
    state_dbg
  };

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
  endtask

  // bus exclusivity every cycle once out of reset
  always @(negedge Clock) begin
    if (mon_en) begin
      chk("bus_excl",
          64'(int'(Read | MDR_enable) +
              int'(MDR_out) + int'(ZLow_out) <= 1),
          64'd1);
    end
  end

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   rd;
    int   alu_n;
    int   wr;
    bit   seen;
    logic [4:0] alu_v;
    rd = 0;
    alu_n = 0;
    wr = 0;
    seen = 0;
    alu_v = '0;
    @(negedge Clock);
    IR_in = {v.opc, 27'h0};
    start = 1'b1;
    mem_ready = 1'b0;
    sb.push_back('{v.legal, v.lat});
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clock);
      start = 1'b0;
      mem_ready = (c >= 2 + v.w);
      if (Read) rd++;
      if (alu_op != 5'd0) begin
        alu_n++;
        alu_v = alu_op;
        chk("alu_in_t4", 64'(state_dbg), 64'd5);
      end
      if (Y_enable | Z_enable | R_in) wr++;
      if ((done || illegal) && sb.size() > 0) begin
        e = sb.pop_front();
        seen = 1;
        chk("kind_illegal", 64'(illegal),
            64'(!e.legal));
        chk("latency", 64'(c), 64'(e.lat));
      end
      if (state_dbg == 4'd0) break;
    end
    chk("output_seen", 64'(seen), 64'd1);
    chk("end_idle", 64'(state_dbg), 64'd0);
    chk("read_cycles", 64'(rd), 64'(1 + v.w));
    if (v.legal) begin
      chk("alu_cnt", 64'(alu_n), 64'd1);
      chk("alu_val", 64'(alu_v), 64'(v.opc));
      chk("wr_cycles", 64'(wr), 64'd3);
    end else begin
      chk("alu_cnt_ill", 64'(alu_n), 64'd0);
      chk("wr_cycles_ill", 64'(wr), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1;
    int dn;
    int endc;
    exp_t e;
    n_pass = 0;
    n_total = 0;
    mon_en = 0;
    clr = 1'b1;
    start = 1'b0;
    run_mode = 1'b0;
    stop = 1'b0;
    mem_ready = 1'b0;
    IR_in = '0;

    vecs[0] = '{OPC_ORI,  0,  1, 6};
    vecs[1] = '{OPC_ANDI, 3,  1, 9};
    vecs[2] = '{OPC_ADDI, 1,  1, 7};
    vecs[3] = '{5'b00000, 0,  0, 4};
    vecs[4] = '{5'b01111, 2,  0, 6};
    vecs[5] = '{5'b11111, 0,  0, 4};
    vecs[6] = '{OPC_ANDI, 14, 1, 20};

    @(negedge Clock);
    @(negedge Clock);
    chk("reset_outs", 64'(outs_all), 64'd0);
    clr = 1'b0;
    mon_en = 1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // wait timeout into FAULT
    @(negedge Clock);
    IR_in = {OPC_ADDI, 27'h0};
    start = 1'b1;
    mem_ready = 1'b0;
    t1 = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clock);
      start = 1'b0;
      if (state_dbg == 4'd2) t1++;
      if (state_dbg == 4'd7) break;
    end
    chk("t1_cycles", 64'(t1), 64'd15);
    chk("fault_state", 64'(state_dbg), 64'd7);
    chk("timeout_set", 64'(timeout), 64'd1);
    chk("fault_busy", 64'(busy), 64'd0);
    start = 1'b1;
    mem_ready = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    start = 1'b0;
    chk("fault_sticky", 64'(state_dbg), 64'd7);
    chk("timeout_held", 64'(timeout), 64'd1);
    clr = 1'b1;
    @(negedge Clock);
    clr = 1'b0;
    chk("clr_state", 64'(state_dbg), 64'd0);
    chk("clr_timeout", 64'(timeout), 64'd0);

    // run mode: three back-to-back ADDI
    run_mode = 1'b1;
    stop = 1'b0;
    mem_ready = 1'b1;
    IR_in = {OPC_ADDI, 27'h0};
    start = 1'b1;
    sb.push_back('{1, 6});
    sb.push_back('{1, 12});
    sb.push_back('{1, 18});
    dn = 0;
    endc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clock);
      start = 1'b0;
      if (done) begin
        dn++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("run_done_cyc", 64'(c), 64'(e.lat));
        end
      end
      if (c == 7 || c == 13)
        chk("run_b2b_t0", 64'(state_dbg), 64'd1);
      if (state_dbg == 4'd5 && dn == 2)
        stop = 1'b1;
      if (state_dbg == 4'd0) begin
        endc = c;
        break;
      end
    end
    chk("run_done_cnt", 64'(dn), 64'd3);
    chk("run_end_cyc", 64'(endc), 64'd19);
    run_mode = 1'b0;
    stop = 1'b0;

    // clr in the middle of T4
    @(negedge Clock);
    IR_in = {OPC_ORI, 27'h0};
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge Clock);
      start = 1'b0;
    end
    chk("pre_clr_t4", 64'(state_dbg), 64'd5);
    chk("pre_clr_alu", 64'(alu_op), 64'(OPC_ORI));
    clr = 1'b1;
    @(negedge Clock);
    clr = 1'b0;
    chk("clr_t4_outs", 64'(outs_all), 64'd0);
    @(negedge Clock);
    chk("clr_t4_stays", 64'(outs_all), 64'd0);

    mon_en = 0;
    @(negedge Clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
